// File: rtl/alu_seq.sv
// alu_seq: clocked, handshaked successor of the lab combinational ALU.
//
// Operands are WIDTH bits and results are 2*WIDTH bits. Add, subtract and
// increment run bit-serially through one full-adder slice over WIDTH cycles.
// Multiply is a shift-add over WIDTH cycles. Logic, reduce-or, concat and
// clear complete on the accepting edge. An accumulator holds the last result
// and can replace operand A.
//
// Ports:
//   clock, resetn         rising-edge clock, async active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   op, a, b, use_acc     request fields, latched on accept
//   out_valid / out_ready result handshake; out_valid is high only in HOLD
//   result                registered 2*WIDTH-bit result
//   busy                  high in EXEC or HOLD
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 use_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_INC = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_LOG = 3'b011;
  localparam logic [2:0] OP_RED = 3'b100;
  localparam logic [2:0] OP_CAT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            state, state_nx;
  logic [2:0]        op_r;
  logic [WIDTH-1:0]  a_sh, b_sh, sum_sh;
  logic [RW-1:0]     mcand, prod;
  logic [CW-1:0]     cnt;
  logic              carry;
  // Only the low half of the accumulator can ever reach an operand, so
  // only that half is stored.
  logic [WIDTH-1:0]  acc;

  logic              accept, serial_op, cnt_last;
  logic [WIDTH-1:0]  opa;
  logic              fa_s, fa_co;
  logic [WIDTH-1:0]  sum_nx;
  logic [RW-1:0]     prod_nx, serial_res, single_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  assign opa       = use_acc ? acc : a;
  assign accept    = in_valid && in_ready;
  assign serial_op = (op == OP_INC) || (op == OP_ADD) ||
                     (op == OP_SUB) || (op == OP_MUL);
  assign cnt_last  = (cnt == CNT_LAST);

  // Single full-adder slice; B was pre-conditioned at accept (zeroed for
  // inc, inverted for sub) so the slice itself never looks at op.
  assign fa_s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_co   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign sum_nx  = {fa_s, sum_sh[WIDTH-1:1]};
  assign prod_nx = prod + (b_sh[0] ? mcand : '0);

  always_comb begin
    serial_res = '0;
    case (op_r)
      OP_MUL:  serial_res = prod_nx;
      // Sub carry-out of A + ~B + 1 is 1 when A >= B; borrow is its inverse.
      OP_SUB:  serial_res = {{(WIDTH-1){1'b0}}, ~fa_co, sum_nx};
      default: serial_res = {{(WIDTH-1){1'b0}}, fa_co, sum_nx};
    endcase
  end

  always_comb begin
    single_res = '0;
    case (op)
      OP_LOG:  single_res = {opa | b, opa ^ b};
      OP_RED:  single_res = {{(RW-1){1'b0}}, |{opa, b}};
      OP_CAT:  single_res = {opa, b};
      default: single_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = serial_op ? EXEC : HOLD;
      EXEC: if (cnt_last) state_nx = HOLD;
      HOLD: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_r   <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      acc    <= '0;
      result <= '0;
    end else if (accept) begin
      op_r   <= op;
      a_sh   <= opa;
      b_sh   <= (op == OP_INC) ? '0 : (op == OP_SUB) ? ~b : b;
      carry  <= (op == OP_INC) || (op == OP_SUB);
      sum_sh <= '0;
      mcand  <= {{WIDTH{1'b0}}, opa};
      prod   <= '0;
      cnt    <= '0;
      if (!serial_op) begin
        result <= single_res;
        acc    <= single_res[WIDTH-1:0];
      end
    end else if (state == EXEC) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_co;
      sum_sh <= sum_nx;
      mcand  <= mcand << 1;
      prod   <= prod_nx;
      cnt    <= cnt + 1'b1;
      if (cnt_last) begin
        result <= serial_res;
        acc    <= serial_res[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=4): directed requests push expected
// results into a queue; a negedge monitor pops and compares on each
// out_valid & out_ready.
module tb_alu_seq;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           resetn, in_valid, out_ready, use_acc;
  logic [2:0]     op;
  logic [W-1:0]   a, b;
  logic           in_ready, out_valid, busy;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] expq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .use_acc(use_acc), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      if (expq.size() == 0) check("unexpected_valid", 32'(out_valid), 32'd0);
      else check("result", 32'(result), 32'(expq.pop_front()));
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (!in_ready && g < 50) begin @(posedge clock); #1; g++; end
    if (!in_ready) check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ua, input logic [2*W-1:0] exp);
    wait_idle();
    op = o; a = aa; b = bb; use_acc = ua; in_valid = 1'b1;
    expq.push_back(exp);
    @(posedge clock); #1;
    // Scramble inputs after accept: they must have been latched.
    in_valid = 1'b0; op = ~o; a = ~aa; b = ~bb; use_acc = ~ua;
  endtask

  // Edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(input string name, input int lat);
    int k = 0;
    while (!out_valid && k < 20) begin @(posedge clock); #1; k++; end
    check(name, 32'(k), 32'(lat));
  endtask

  initial begin
    bit seen;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; use_acc = 1'b0;
    #12;
    check("rst_result", 32'(result), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    // A request during reset must not be accepted.
    in_valid = 1'b1; op = 3'b011; a = 4'h5; b = 4'h5;
    @(posedge clock); #1;
    check("rst_no_accept", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    issue(3'b000, 4'hF, 4'h0, 1'b0, 8'h10); wait_valid("inc_lat", 4);
    issue(3'b001, 4'h9, 4'h8, 1'b0, 8'h11); wait_valid("add_lat", 4);
    issue(3'b010, 4'h3, 4'h5, 1'b0, 8'h1E); wait_valid("sub_lat", 4);
    issue(3'b110, 4'hF, 4'hF, 1'b0, 8'hE1); wait_valid("mul_ff_lat", 4);
    issue(3'b110, 4'h0, 4'h7, 1'b0, 8'h00); wait_valid("mul_0_lat", 4);
    issue(3'b011, 4'hA, 4'h6, 1'b0, 8'hEC); wait_valid("logic_lat", 0);
    issue(3'b101, 4'h3, 4'hC, 1'b0, 8'h3C); wait_valid("cat_lat", 0);
    issue(3'b100, 4'h0, 4'h0, 1'b0, 8'h00); wait_valid("red0_lat", 0);
    issue(3'b100, 4'h0, 4'h2, 1'b0, 8'h01); wait_valid("red1_lat", 0);

    // Backpressure
    wait_idle();
    out_ready = 1'b0;
    issue(3'b001, 4'h1, 4'h2, 1'b0, 8'h03); wait_valid("bp_lat", 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
      @(posedge clock); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'h03);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Accumulator chain
    issue(3'b110, 4'h3, 4'h5, 1'b0, 8'h0F); wait_valid("acc_mul_lat", 4);
    issue(3'b001, 4'h7, 4'h1, 1'b1, 8'h10); wait_valid("acc_add_lat", 4);
    issue(3'b111, 4'h5, 4'h5, 1'b1, 8'h00); wait_valid("clr_lat", 0);
    issue(3'b001, 4'h9, 4'h2, 1'b1, 8'h02); wait_valid("acc_add2_lat", 4);

    // Reset in the second EXEC cycle aborts the operation.
    wait_idle();
    op = 3'b110; a = 4'h3; b = 4'h3; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1; in_valid = 1'b0;
    @(posedge clock); #2;
    resetn = 1'b0; #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'h0);
    @(negedge clock); resetn = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clock); #1; if (out_valid) seen = 1'b1; end
    check("abort_no_valid", 32'(seen), 32'd0);
    // acc was cleared by reset: 0 + 1.
    issue(3'b001, 4'h9, 4'h1, 1'b1, 8'h01); wait_valid("post_abort_lat", 4);

    wait_idle();
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
